// File: rtl/wb_resp_pkg.sv
// Shared definitions for the Wishbone memory responder: bus encodings,
// FSM states, configuration bundle and the burst wrap-mask helper.
package wb_resp_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_BURST
    } state_e;

    typedef struct packed {
        logic [3:0]  wait_cycles;
        logic        err_en;
        logic [31:0] err_adr;
    } wb_resp_cfg_s;

    // Low word-address bits that wrap for a given burst type; 0 means no wrap.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 4'h3;
            BTE_WRAP8:  return 4'h7;
            BTE_WRAP16: return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word address of an incrementing Wishbone burst: linear +1, or wrapN
// where only the low log2(N) bits count modulo N.
module wb_burst_addr_gen
    import wb_resp_pkg::*;
#(
    parameter int WIDTH = 30
) (
    input  logic [WIDTH-1:0] cur_adr_i,
    input  logic [1:0]       bte_i,
    output logic [WIDTH-1:0] next_adr_o
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] incr;
    logic [WIDTH-1:0] mask;

    always_comb begin
        incr = cur_adr_i + ONE;
        if (bte_i == BTE_LINEAR) begin
            mask = '1;
        end else begin
            mask = {{(WIDTH-4){1'b0}}, wrap_mask(bte_i)};
        end
        next_adr_o = (cur_adr_i & ~mask) | (incr & mask);
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B3 slave with internal word memory: classic and incrementing
// burst cycles, programmable first-beat wait states, error injection.
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [ADDR_WIDTH-1:0]     s_wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0]   s_wb_sel_i,
    input  logic                      s_wb_we_i,
    input  logic [DATA_WIDTH-1:0]     s_wb_dat_i,
    output logic [DATA_WIDTH-1:0]     s_wb_dat_o,
    input  logic                      s_wb_cyc_i,
    input  logic                      s_wb_stb_i,
    input  logic [2:0]                s_wb_cti_i,
    input  logic [1:0]                s_wb_bte_i,
    output logic                      s_wb_ack_o,
    output logic                      s_wb_err_o,
    input  logic [3:0]                cfg_wait_i,
    input  logic                      err_en_i,
    input  logic [31:0]               err_adr_i,
    output logic                      burst_mismatch_o,
    output logic [CNT_WIDTH-1:0]      xfer_cnt_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int WADR_W    = ADDR_WIDTH - 2;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    wb_resp_cfg_s cfg;
    assign cfg = {cfg_wait_i, err_en_i, err_adr_i};

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [WADR_W-1:0]     adr_q, adr_d;
    logic                  we_q, we_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [2:0]            cti_q, cti_d;
    logic [1:0]            bte_q, bte_d;
    logic [WADR_W-1:0]     pred_q, pred_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;

    logic                  in_burst;
    logic [WADR_W-1:0]     cur_wadr;
    logic                  cur_we;
    logic [SEL_WIDTH-1:0]  cur_sel;
    logic [DATA_WIDTH-1:0] cur_dat;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_err;
    logic                  beat;
    logic                  ack;
    logic                  errb;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [WADR_W-1:0]     gen_cur;
    logic [WADR_W-1:0]     gen_next;

    logic unused_bits;
    assign unused_bits = ^{s_wb_adr_i[1:0], cfg.err_adr[1:0]};

    // RESP serves the latched request; BURST serves whatever beat is on the bus.
    always_comb begin
        in_burst = (state_q == ST_BURST);
        cur_wadr = in_burst ? s_wb_adr_i[ADDR_WIDTH-1:2] : adr_q;
        cur_we   = in_burst ? s_wb_we_i  : we_q;
        cur_sel  = in_burst ? s_wb_sel_i : sel_q;
        cur_dat  = in_burst ? s_wb_dat_i : dat_q;
        cur_idx  = cur_wadr[IDX_W-1:0];
        cur_err  = (cfg.err_en && (cur_wadr == cfg.err_adr[31:2]))
                 || (|cur_wadr[WADR_W-1:IDX_W]);
        beat     = s_wb_cyc_i && ((state_q == ST_RESP) || (in_burst && s_wb_stb_i));
        ack      = beat && !cur_err;
        errb     = beat && cur_err;
        wr_en    = ack && cur_we && !wb_rst_i;
        gen_cur  = in_burst ? pred_q : adr_q;
    end

    wb_burst_addr_gen #(
        .WIDTH (WADR_W)
    ) u_addr_gen (
        .cur_adr_i  (gen_cur),
        .bte_i      (bte_q),
        .next_adr_o (gen_next)
    );

    // Byte-lane memories; the read port is asynchronous so a burst beat can
    // be answered in the same cycle its address is presented.
    genvar gi;
    for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
        logic [7:0] mem [MEM_WORDS];

        always_ff @(posedge wb_clk_i) begin
            if (wr_en && cur_sel[gi]) begin
                mem[cur_idx] <= cur_dat[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = mem[cur_idx];
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        pred_d  = pred_q;
        rdata_d = (ack && !cur_we) ? rd_word : rdata_q;
        xfer_d  = ack ? (xfer_q + CNT_ONE) : xfer_q;

        case (state_q)
            ST_IDLE: begin
                if (s_wb_cyc_i && s_wb_stb_i) begin
                    adr_d   = s_wb_adr_i[ADDR_WIDTH-1:2];
                    we_d    = s_wb_we_i;
                    sel_d   = s_wb_sel_i;
                    dat_d   = s_wb_dat_i;
                    cti_d   = s_wb_cti_i;
                    bte_d   = s_wb_bte_i;
                    wait_d  = cfg.wait_cycles;
                    state_d = (cfg.wait_cycles == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!s_wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                    if (wait_d == 4'd0) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (!s_wb_cyc_i || errb || (cti_q != CTI_INCR)) begin
                    state_d = ST_IDLE;
                end else begin
                    pred_d  = gen_next;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!s_wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (s_wb_stb_i) begin
                    pred_d = gen_next;
                    if (errb || (s_wb_cti_i == CTI_EOB)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            cti_q   <= CTI_CLASSIC;
            bte_q   <= BTE_LINEAR;
            pred_q  <= '0;
            rdata_q <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            pred_q  <= pred_d;
            rdata_q <= rdata_d;
            xfer_q  <= xfer_d;
        end
    end

    assign s_wb_ack_o       = ack;
    assign s_wb_err_o       = errb;
    assign burst_mismatch_o = ack && in_burst && (cur_wadr != pred_q);
    assign s_wb_dat_o       = (ack && !cur_we) ? rd_word : rdata_q;
    assign xfer_cnt_o       = xfer_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed self-checking bench for wb_mem_responder.
module tb_wb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic [3:0]  cfg_wait;
    logic        err_en;
    logic [31:0] err_adr;
    logic        mism;
    logic [15:0] xfer;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_mem_responder dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .s_wb_adr_i       (adr),
        .s_wb_sel_i       (sel),
        .s_wb_we_i        (we),
        .s_wb_dat_i       (wdat),
        .s_wb_dat_o       (rdat),
        .s_wb_cyc_i       (cyc),
        .s_wb_stb_i       (stb),
        .s_wb_cti_i       (cti),
        .s_wb_bte_i       (bte),
        .s_wb_ack_o       (ack),
        .s_wb_err_o       (err),
        .cfg_wait_i       (cfg_wait),
        .err_en_i         (err_en),
        .err_adr_i        (err_adr),
        .burst_mismatch_o (mism),
        .xfer_cnt_o       (xfer)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
        bte = 2'b00;
    endtask

    task automatic classic(input string tag, input logic wr, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d, input int waits,
                           input logic exp_err, input logic chk_dat, input logic [31:0] exp_dat);
        cfg_wait = 4'(waits);
        adr = a; sel = s; we = wr; wdat = d;
        cti = 3'b000; bte = 2'b00;
        cyc = 1'b1; stb = 1'b1;
        tick();
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_early"}, {30'd0, ack, err}, 32'd0);
            tick();
        end
        chk({tag, "_ack"}, {31'd0, ack}, {31'd0, !exp_err});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (chk_dat) chk({tag, "_dat"}, rdat, exp_dat);
        $display("txn %s we=%0d adr=%h sel=%b wdat=%h waits=%0d ack=%0d err=%0d rdat=%h",
                 tag, wr, a, s, d, waits, ack, err, rdat);
        tick();
        idle_bus();
        #1;
        chk({tag, "_release"}, {30'd0, ack, err}, 32'd0);
    endtask

    task automatic burst(input string tag, input logic [1:0] bt, input logic [3:0][31:0] adrs,
                         input logic [3:0][31:0] exp_dat, input logic [3:0] dat_ok,
                         input logic [3:0] exp_mis);
        cfg_wait = 4'd0;
        adr = adrs[0]; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = bt;
        cyc = 1'b1; stb = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                adr = adrs[i];
                cti = (i == 3) ? 3'b111 : 3'b010;
                #1;
            end
            chk($sformatf("%s_b%0d_ack", tag, i), {31'd0, ack}, 32'd1);
            chk($sformatf("%s_b%0d_mis", tag, i), {31'd0, mism}, {31'd0, exp_mis[i]});
            if (dat_ok[i]) chk($sformatf("%s_b%0d_dat", tag, i), rdat, exp_dat[i]);
            $display("txn %s beat=%0d adr=%h ack=%0d err=%0d mismatch=%0d rdat=%h",
                     tag, i, adrs[i], ack, err, mism, rdat);
        end
        tick();
        idle_bus();
        #1;
        chk({tag, "_done"}, {30'd0, ack, err}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adr = '0; sel = '0; wdat = '0;
        cfg_wait = '0; err_en = 1'b0; err_adr = 32'h0000_0200;
        idle_bus();
        tick();
        tick();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_mis", {31'd0, mism}, 32'd0);
        chk("rst_xfer", {16'd0, xfer}, 32'd0);
        rst = 1'b0;
        tick();

        // Classic full and partial writes with readback.
        classic("wr100", 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0);
        classic("rd100", 1'b0, 32'h100, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("xfer_after_2", {16'd0, xfer}, 32'd2);
        classic("wr100p", 1'b1, 32'h100, 4'b0010, 32'h0000AB00, 0, 1'b0, 1'b0, 32'h0);
        classic("rd100p", 1'b0, 32'h100, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'hDEADABEF);

        // Seed words for the wait-state read and the bursts.
        classic("wr104", 1'b1, 32'h104, 4'hF, 32'h11223344, 0, 1'b0, 1'b0, 32'h0);
        classic("wr108", 1'b1, 32'h108, 4'hF, 32'hA5A50108, 0, 1'b0, 1'b0, 32'h0);
        classic("wr10c", 1'b1, 32'h10C, 4'hF, 32'h5A5A010C, 0, 1'b0, 1'b0, 32'h0);
        classic("rd104w3", 1'b0, 32'h104, 4'hF, 32'h0, 3, 1'b0, 1'b1, 32'h11223344);
        chk("xfer_after_8", {16'd0, xfer}, 32'd8);

        burst("wrap4", 2'b01, {32'h104, 32'h100, 32'h10C, 32'h108},
              {32'h11223344, 32'hDEADABEF, 32'h5A5A010C, 32'hA5A50108}, 4'b1111, 4'b0000);
        burst("wrap4mis", 2'b01, {32'h104, 32'h110, 32'h10C, 32'h108},
              {32'h11223344, 32'h0, 32'h5A5A010C, 32'hA5A50108}, 4'b1011, 4'b0100);
        chk("xfer_after_16", {16'd0, xfer}, 32'd16);

        // Error injection: the err write must not touch memory or the counter.
        classic("wr200", 1'b1, 32'h200, 4'hF, 32'h0BADF00D, 0, 1'b0, 1'b0, 32'h0);
        err_en = 1'b1;
        classic("wr200err", 1'b1, 32'h200, 4'hF, 32'hFFFFFFFF, 0, 1'b1, 1'b1, 32'h11223344);
        chk("xfer_after_err", {16'd0, xfer}, 32'd17);
        err_en = 1'b0;
        classic("rd200", 1'b0, 32'h200, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'h0BADF00D);
        classic("rd_oob", 1'b0, 32'h1000, 4'hF, 32'h0, 0, 1'b1, 1'b1, 32'h0BADF00D);
        chk("xfer_after_oob", {16'd0, xfer}, 32'd18);

        // Abort during wait states: no response, no write.
        cfg_wait = 4'd5;
        adr = 32'h100; sel = 4'hF; we = 1'b1; wdat = 32'h12345678;
        cyc = 1'b1; stb = 1'b1;
        tick();
        chk("abort_w0", {30'd0, ack, err}, 32'd0);
        tick();
        chk("abort_w1", {30'd0, ack, err}, 32'd0);
        tick();
        idle_bus();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("abort_quiet%0d", i), {30'd0, ack, err}, 32'd0);
            tick();
        end
        $display("txn abort we=1 adr=00000100 cyc dropped after 2 wait cycles");
        chk("xfer_after_abort", {16'd0, xfer}, 32'd18);
        cfg_wait = 4'd0;

        // Reset in the middle of a linear burst.
        adr = 32'h104; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        cyc = 1'b1; stb = 1'b1;
        tick();
        chk("rstb_b0_ack", {31'd0, ack}, 32'd1);
        chk("rstb_b0_dat", rdat, 32'h11223344);
        tick();
        adr = 32'h108;
        #1;
        chk("rstb_b1_ack", {31'd0, ack}, 32'd1);
        chk("rstb_b1_mis", {31'd0, mism}, 32'd0);
        chk("rstb_b1_dat", rdat, 32'hA5A50108);
        rst = 1'b1;
        adr = 32'h10C;
        tick();
        chk("rstb_ack", {31'd0, ack}, 32'd0);
        chk("rstb_err", {31'd0, err}, 32'd0);
        chk("rstb_dat", rdat, 32'd0);
        chk("rstb_mis", {31'd0, mism}, 32'd0);
        chk("rstb_xfer", {16'd0, xfer}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wins_req", {31'd0, ack}, 32'd0);
        $display("txn reset_mid_burst xfer=%0d ack=%0d", xfer, ack);
        idle_bus();
        tick();

        classic("post_rd100", 1'b0, 32'h100, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'hDEADABEF);
        classic("post_rd200", 1'b0, 32'h200, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'h0BADF00D);
        classic("post_rd10c", 1'b0, 32'h10C, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'h5A5A010C);
        chk("xfer_post_rst", {16'd0, xfer}, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
